// File: rtl/r2_sdf_butterfly_if.sv
// Streaming port bundle for the radix-2 single-delay-feedback butterfly.
// The master drives samples and control; the slave returns results.
interface r2_sdf_butterfly_if #(
  parameter int WIDTH     = 26,
  parameter int LOG2_HALF = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] data_in_r;
  logic signed [WIDTH-1:0] data_in_i;
  logic                    scale;
  logic                    flush;
  logic                    out_valid;
  logic signed [WIDTH:0]   data_out_r;
  logic signed [WIDTH:0]   data_out_i;
  logic [LOG2_HALF:0]      out_index;
  logic                    out_last;

  modport master (
    output in_valid, data_in_r, data_in_i, scale, flush,
    input  in_ready, out_valid, data_out_r, data_out_i, out_index, out_last
  );

  modport slave (
    input  in_valid, data_in_r, data_in_i, scale, flush,
    output in_ready, out_valid, data_out_r, data_out_i, out_index, out_last
  );
endinterface

// File: rtl/r2_sdf_butterfly.sv
// Radix-2 SDF butterfly: first half-frame is parked in a delay line, second half
// produces sums immediately and parks differences for the next frame or a drain.
module r2_sdf_butterfly #(
  parameter int WIDTH     = 26,
  parameter int LOG2_HALF = 10
) (
  input  logic               clk,
  input  logic               rst,
  r2_sdf_butterfly_if.slave  bus
);
  localparam int HALF = 1 << LOG2_HALF;
  localparam int MW   = WIDTH + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [LOG2_HALF-1:0] idx_reg, idx_next;
  logic                 phase_reg, phase_next;
  logic                 pending_reg, pending_next;
  logic                 scale_reg, scale_next;
  logic                 out_valid_reg, out_valid_next;
  logic                 out_last_reg, out_last_next;
  logic [LOG2_HALF:0]   out_index_reg, out_index_next;
  logic signed [MW-1:0] out_data_reg [2];
  logic signed [MW-1:0] out_data_next [2];

  // Lane 0 carries the real component, lane 1 the imaginary one.
  logic signed [MW-1:0] x_c   [2];
  logic signed [MW-1:0] rd_c  [2];
  logic signed [MW-1:0] sum_c [2];
  logic signed [MW-1:0] dif_c [2];
  logic                 mem_we;
  logic                 last_idx;

  assign x_c[0]   = {bus.data_in_r[WIDTH-1], bus.data_in_r};
  assign x_c[1]   = {bus.data_in_i[WIDTH-1], bus.data_in_i};
  assign last_idx = &idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      // Asynchronous read keeps the accepted-sample-to-output latency at one cycle.
      logic signed [MW-1:0] mem [HALF];
      logic signed [MW-1:0] full_s;
      logic signed [MW-1:0] full_d;
      logic signed [MW-1:0] wd;

      assign rd_c[gi]  = mem[idx_reg];
      assign full_s    = rd_c[gi] + x_c[gi];
      assign full_d    = rd_c[gi] - x_c[gi];
      assign sum_c[gi] = scale_reg ? (full_s >>> 1) : full_s;
      assign dif_c[gi] = scale_reg ? (full_d >>> 1) : full_d;
      assign wd        = phase_reg ? dif_c[gi] : x_c[gi];

      always_ff @(posedge clk) begin
        if (mem_we) begin
          mem[idx_reg] <= wd;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      idx_reg         <= '0;
      phase_reg       <= 1'b0;
      pending_reg     <= 1'b0;
      scale_reg       <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      out_index_reg   <= '0;
      out_data_reg[0] <= '0;
      out_data_reg[1] <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      phase_reg       <= phase_next;
      pending_reg     <= pending_next;
      scale_reg       <= scale_next;
      out_valid_reg   <= out_valid_next;
      out_last_reg    <= out_last_next;
      out_index_reg   <= out_index_next;
      out_data_reg[0] <= out_data_next[0];
      out_data_reg[1] <= out_data_next[1];
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    phase_next       = phase_reg;
    pending_next     = pending_reg;
    scale_next       = scale_reg;
    out_valid_next   = 1'b0;
    out_last_next    = 1'b0;
    out_index_next   = out_index_reg;
    out_data_next[0] = out_data_reg[0];
    out_data_next[1] = out_data_reg[1];
    mem_we           = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (bus.in_valid) begin
          mem_we   = 1'b1;
          idx_next = idx_reg + 1'b1;
          if (last_idx) begin
            phase_next = ~phase_reg;
          end
          if (!phase_reg) begin
            if (idx_reg == '0) begin
              scale_next = bus.scale;
            end
            // Previous frame's difference leaves as its slot is overwritten.
            if (pending_reg) begin
              out_valid_next   = 1'b1;
              out_index_next   = {1'b1, idx_reg};
              out_last_next    = last_idx;
              out_data_next[0] = rd_c[0];
              out_data_next[1] = rd_c[1];
              if (last_idx) begin
                pending_next = 1'b0;
              end
            end
          end else begin
            out_valid_next   = 1'b1;
            out_index_next   = {1'b0, idx_reg};
            out_data_next[0] = sum_c[0];
            out_data_next[1] = sum_c[1];
            if (last_idx) begin
              pending_next = 1'b1;
            end
          end
        end else if (bus.flush && pending_reg && !phase_reg && idx_reg == '0) begin
          state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        idx_next         = idx_reg + 1'b1;
        out_valid_next   = 1'b1;
        out_index_next   = {1'b1, idx_reg};
        out_last_next    = last_idx;
        out_data_next[0] = rd_c[0];
        out_data_next[1] = rd_c[1];
        if (last_idx) begin
          pending_next = 1'b0;
          state_next   = ST_RUN;
        end
      end

      default: state_next = ST_RUN;
    endcase
  end

  assign bus.in_ready   = (state_reg != ST_DRAIN);
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_last   = out_last_reg;
  assign bus.out_index  = out_index_reg;
  assign bus.data_out_r = out_data_reg[0];
  assign bus.data_out_i = out_data_reg[1];
endmodule

// File: tb/tb_r2_sdf_butterfly.sv
// Bench for r2_sdf_butterfly: frame-level reference model checked every cycle,
// plus literal expectations for the directed frames.
`timescale 1ns/1ps
module tb_r2_sdf_butterfly;
  localparam int WIDTH     = 26;
  localparam int LOG2_HALF = 2;
  localparam int HALF      = 4;
  localparam int N         = 8;

  localparam longint SEQ_R [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  localparam longint ZERO8 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  localparam longint A_R   [8] = '{3, -1, 4, 1, -5, 9, 2, -6};
  localparam longint A_I   [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  localparam longint SC_R  [8] = '{7, 0, 0, 0, -8, 0, 0, 0};
  localparam longint MX_R  [8] = '{33554431, 0, 0, 0, 33554431, 0, 0, 0};
  localparam longint MX_I  [8] = '{-33554432, 0, 0, 0, -33554432, 0, 0, 0};
  localparam longint Z4    [4] = '{0, 0, 0, 0};
  localparam longint T1_S  [4] = '{6, 8, 10, 12};
  localparam longint T1_D  [4] = '{-4, -4, -4, -4};
  localparam longint T2_SR [4] = '{-2, 8, 6, -5};
  localparam longint T2_SI [4] = '{4, 6, 8, 10};
  localparam longint T2_DR [4] = '{8, -10, 2, 7};
  localparam longint T3_S  [4] = '{-1, 0, 0, 0};
  localparam longint T3_D  [4] = '{7, 0, 0, 0};
  localparam longint T4_SR [4] = '{67108862, 0, 0, 0};
  localparam longint T4_SI [4] = '{-67108864, 0, 0, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;

  r2_sdf_butterfly_if #(.WIDTH(WIDTH), .LOG2_HALF(LOG2_HALF)) bus ();

  r2_sdf_butterfly #(.WIDTH(WIDTH), .LOG2_HALF(LOG2_HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position within frame, stored first half, queued differences.
  int     pos;
  longint fx_r [N];
  longint fx_i [N];
  bit     fscale;
  longint pd_r [$];
  longint pd_i [$];
  int     pd_ix [$];
  int     drain_left;
  bit     due_valid;
  longint due_r, due_i;
  int     due_ix;
  longint last_r, last_i;

  longint log_r [$];
  longint log_i [$];
  int     log_ix [$];
  bit     log_last [$];

  longint rr [8];
  longint ri [8];

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pop_diff();
    due_valid = 1'b1;
    due_r     = pd_r.pop_front();
    due_i     = pd_i.pop_front();
    due_ix    = pd_ix.pop_front();
  endtask

  // Called at the falling edge: check what the last rising edge produced, then
  // predict what the next rising edge must produce from the inputs now applied.
  task automatic monitor();
    longint ar, ai, xr, xi, s_r, s_i, d_r, d_i;
    int     k;
    ar = $signed(bus.data_out_r);
    ai = $signed(bus.data_out_i);
    if (rst) begin
      pos = 0; drain_left = 0; due_valid = 1'b0;
      pd_r.delete(); pd_i.delete(); pd_ix.delete();
      last_r = 0; last_i = 0;
      chk("rst_in_ready", longint'(bus.in_ready), 1);
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_out_last", longint'(bus.out_last), 0);
      chk("rst_out_index", longint'(bus.out_index), 0);
      chk("rst_data_r", ar, 0);
      chk("rst_data_i", ai, 0);
      return;
    end
    chk("in_ready", longint'(bus.in_ready), (drain_left == 0) ? 1 : 0);
    chk("out_valid", longint'(bus.out_valid), longint'(due_valid));
    if (due_valid) begin
      chk("data_r", ar, due_r);
      chk("data_i", ai, due_i);
      chk("out_index", longint'(bus.out_index), due_ix);
      chk("out_last", longint'(bus.out_last), (due_ix == N - 1) ? 1 : 0);
      last_r = due_r;
      last_i = due_i;
    end else begin
      chk("hold_r", ar, last_r);
      chk("hold_i", ai, last_i);
    end
    if (bus.out_valid) begin
      log_r.push_back(ar);
      log_i.push_back(ai);
      log_ix.push_back(int'(bus.out_index));
      log_last.push_back(bus.out_last);
    end

    xr = $signed(bus.data_in_r);
    xi = $signed(bus.data_in_i);
    due_valid = 1'b0;
    if (drain_left > 0) begin
      pop_diff();
      drain_left--;
    end else if (bus.in_valid) begin
      if (pos < HALF) begin
        fx_r[pos] = xr;
        fx_i[pos] = xi;
        if (pos == 0) fscale = bus.scale;
        if (pd_r.size() > 0) pop_diff();
      end else begin
        k   = pos - HALF;
        s_r = fx_r[k] + xr;  s_i = fx_i[k] + xi;
        d_r = fx_r[k] - xr;  d_i = fx_i[k] - xi;
        if (fscale) begin
          s_r = s_r >>> 1; s_i = s_i >>> 1;
          d_r = d_r >>> 1; d_i = d_i >>> 1;
        end
        due_valid = 1'b1;
        due_r = s_r; due_i = s_i; due_ix = k;
        pd_r.push_back(d_r);
        pd_i.push_back(d_i);
        pd_ix.push_back(HALF + k);
      end
      pos = (pos + 1) % N;
    end else if (bus.flush && pos == 0 && pd_r.size() > 0) begin
      drain_left = HALF;
    end
  endtask

  task automatic step(input bit v, input longint r, input longint i, input bit sc, input bit fl);
    bus.in_valid  = v;
    bus.data_in_r = WIDTH'(r);
    bus.data_in_i = WIDTH'(i);
    bus.scale     = sc;
    bus.flush     = fl;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Scale is asserted only on sample 0 (inverted elsewhere) so latching is exercised.
  task automatic send_frame(input longint xr[8], input longint xi[8], input bit sc, input bit gappy);
    for (int k = 0; k < N; k++) begin
      if (gappy && k > 0) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 999, -999, ~sc, 1'b1);
      end
      step(1'b1, xr[k], xi[k], (k == 0) ? sc : ~sc, 1'b0);
    end
  endtask

  task automatic drain();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (HALF + 1) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_seg(input string name, input int at, input longint er[4],
                           input longint ei[4], input int ix0);
    for (int j = 0; j < 4; j++) begin
      if (at + j >= log_r.size()) begin
        chk({name, "_present"}, log_r.size(), at + j + 1);
      end else begin
        chk({name, "_r"}, log_r[at + j], er[j]);
        chk({name, "_i"}, log_i[at + j], ei[j]);
        chk({name, "_ix"}, log_ix[at + j], ix0 + j);
      end
    end
  endtask

  initial begin
    int mark;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.scale = 1'b0;
    bus.data_in_r = '0;  bus.data_in_i = '0;
    pos = 0; drain_left = 0; due_valid = 1'b0; fscale = 1'b0;
    last_r = 0; last_i = 0;
    @(posedge clk);
    #1;
    do_reset(2);
    $display("reset: checked reset state");

    // Flush with nothing pending must be ignored.
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0);

    mark = log_r.size();
    send_frame(SEQ_R, ZERO8, 1'b0, 1'b0);
    drain();
    chk("t1_count", log_r.size() - mark, 8);
    check_seg("t1_sum", mark, T1_S, Z4, 0);
    check_seg("t1_dif", mark + 4, T1_D, Z4, 4);
    if (log_r.size() >= mark + 8) chk("t1_last", longint'(log_last[mark + 7]), 1);
    $display("frame 1..8: %0d outputs, first sum %0d", log_r.size() - mark,
             (log_r.size() > mark) ? log_r[mark] : 0);

    mark = log_r.size();
    send_frame(A_R, A_I, 1'b0, 1'b0);
    send_frame(ZERO8, ZERO8, 1'b0, 1'b0);
    drain();
    chk("t2_count", log_r.size() - mark, 16);
    check_seg("t2_sum", mark, T2_SR, T2_SI, 0);
    check_seg("t2_dif", mark + 4, T2_DR, T1_D, 4);
    check_seg("t2_zero", mark + 8, Z4, Z4, 0);
    $display("back-to-back frames: %0d outputs", log_r.size() - mark);

    mark = log_r.size();
    send_frame(SC_R, ZERO8, 1'b1, 1'b0);
    drain();
    check_seg("t3_sum", mark, T3_S, Z4, 0);
    check_seg("t3_dif", mark + 4, T3_D, Z4, 4);
    $display("scaled frame: sum0 %0d", (log_r.size() > mark) ? log_r[mark] : 0);

    mark = log_r.size();
    send_frame(MX_R, MX_I, 1'b0, 1'b0);
    drain();
    check_seg("t4_sum", mark, T4_SR, T4_SI, 0);
    check_seg("t4_dif", mark + 4, Z4, Z4, 4);
    $display("extreme inputs: sum0 %0d", (log_r.size() > mark) ? log_r[mark] : 0);

    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        rr[k] = longint'($urandom_range(0, 2000)) - 1000;
        ri[k] = longint'($urandom_range(0, 2000)) - 1000;
      end
      mark = log_r.size();
      send_frame(rr, ri, f[0], 1'b1);
      $display("gappy frame %0d: %0d outputs", f, log_r.size() - mark);
    end
    drain();

    send_frame(SEQ_R, ZERO8, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0);
    do_reset(2);
    mark = log_r.size();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    send_frame(SEQ_R, ZERO8, 1'b0, 1'b0);
    drain();
    chk("t6_count", log_r.size() - mark, 8);
    check_seg("t6_sum", mark, T1_S, Z4, 0);
    check_seg("t6_dif", mark + 4, T1_D, Z4, 4);
    $display("reset during drain: %0d outputs after reset", log_r.size() - mark);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
